// File: rtl/gpio_in_pkg.sv
// Shared constants for the GPIO input peripheral: register offsets and debounce counter width.
package gpio_in_pkg;

    localparam logic [1:0] OFF_LEVEL = 2'd0;
    localparam logic [1:0] OFF_RISE  = 2'd1;
    localparam logic [1:0] OFF_FALL  = 2'd2;
    localparam logic [1:0] OFF_MASK  = 2'd3;

    localparam int unsigned DBNC_CNT_WIDTH = 8;

endpackage

// File: rtl/gpio_in_ctrl_debounce.sv
// One GPIO input bit: synchronizer, debounce counter, accepted stable level and edge pulses.
module gpio_debounce
    import gpio_in_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [DBNC_CNT_WIDTH-1:0] CNT_LAST = DBNC_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                      meta_q, meta_d;
    logic                      sync_q, sync_d;
    logic                      samp_q, samp_d;
    logic                      stable_q, stable_d;
    logic [DBNC_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer plus one sample stage, so a pin change reaches
    // the stable level 2+DEBOUNCE_CYCLES edges after it is first sampled.
    always_comb begin
        meta_d   = pin_i;
        sync_d   = meta_q;
        samp_d   = sync_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (samp_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = samp_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            samp_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            samp_q   <= samp_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = stable_d & ~stable_q;
    assign fall_o  = ~stable_d & stable_q;

endmodule

// File: rtl/gpio_in_ctrl.sv
// Memory-mapped GPIO input peripheral: debounced levels, sticky read-clear edge
// registers, interrupt mask, registered read data and a level interrupt.
module gpio_in_ctrl
    import gpio_in_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           GPIO_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'hFFFF_FF00,
    parameter int unsigned           DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    input  logic                  data_rd_en,
    input  logic                  data_wr_en,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_write,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  rd_valid,
    output logic                  irq
);

    logic [GPIO_WIDTH-1:0] level, rise_p, fall_p;
    logic [GPIO_WIDTH-1:0] rise_q, rise_d;
    logic [GPIO_WIDTH-1:0] fall_q, fall_d;
    logic [GPIO_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] data_read_q, data_read_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  irq_q, irq_d;
    logic                  hit, rd_hit, wr_hit;
    logic [1:0]            offset;
    logic [GPIO_WIDTH-1:0] rd_sel;

    // Byte-lane bits of the address and write data above GPIO_WIDTH carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{data_addr[1:0], data_write};

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_dbnc (
            .clk    (clk),
            .rst    (rst),
            .pin_i  (gpio_i[i]),
            .level_o(level[i]),
            .rise_o (rise_p[i]),
            .fall_o (fall_p[i])
        );
    end

    always_comb begin
        hit    = (data_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
        offset = data_addr[3:2];
        rd_hit = data_rd_en & hit;
        wr_hit = data_wr_en & hit;

        case (offset)
            OFF_LEVEL: rd_sel = level;
            OFF_RISE:  rd_sel = rise_q;
            OFF_FALL:  rd_sel = fall_q;
            default:   rd_sel = mask_q;
        endcase

        data_read_d = '0;
        if (rd_hit) begin
            data_read_d[GPIO_WIDTH-1:0] = rd_sel;
        end
        rd_valid_d = rd_hit;

        // A read-clear drops every bit it returns; events landing on the same edge survive.
        rise_d = rise_q | rise_p;
        fall_d = fall_q | fall_p;
        if (rd_hit && offset == OFF_RISE) begin
            rise_d = rise_p;
        end
        if (rd_hit && offset == OFF_FALL) begin
            fall_d = fall_p;
        end

        mask_d = mask_q;
        if (wr_hit && offset == OFF_MASK) begin
            mask_d = data_write[GPIO_WIDTH-1:0];
        end

        irq_d = |((rise_q | fall_q) & mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q      <= '0;
            fall_q      <= '0;
            mask_q      <= '0;
            data_read_q <= '0;
            rd_valid_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            mask_q      <= mask_d;
            data_read_q <= data_read_d;
            rd_valid_q  <= rd_valid_d;
            irq_q       <= irq_d;
        end
    end

    assign data_read = data_read_q;
    assign rd_valid  = rd_valid_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_in_ctrl.sv
// Directed bench for gpio_in_ctrl with DEBOUNCE_CYCLES=16 and 32 pins.
module tb_gpio_in_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] A_LEVEL = BASE + 32'd0;
    localparam logic [31:0] A_RISE  = BASE + 32'd4;
    localparam logic [31:0] A_FALL  = BASE + 32'd8;
    localparam logic [31:0] A_MASK  = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_i;
    logic        data_rd_en;
    logic        data_wr_en;
    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        rd_valid;
    logic        irq;

    int tests = 0;
    int fails = 0;

    gpio_in_ctrl #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .GPIO_WIDTH     (32),
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_i    (gpio_i),
        .data_rd_en(data_rd_en),
        .data_wr_en(data_wr_en),
        .data_addr (data_addr),
        .data_write(data_write),
        .data_read (data_read),
        .rd_valid  (rd_valid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Advance n active edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        data_rd_en = 1'b1;
        data_addr  = addr;
        tick(1);
        data_rd_en = 1'b0;
        check({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
        check(tag, data_read, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] val);
        data_wr_en = 1'b1;
        data_addr  = addr;
        data_write = val;
        tick(1);
        data_wr_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        gpio_i     = '0;
        data_rd_en = 1'b1;
        data_wr_en = 1'b0;
        data_addr  = A_LEVEL;
        data_write = '0;

        // Reset with a read strobe present: no read response.
        tick(1);
        data_rd_en = 1'b0;
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_data", data_read, 32'd0);
        tick(2);
        check("rst_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;

        // Post-reset register contents; LEVEL via an address with low bits set.
        rd(A_LEVEL + 32'd3, 32'h0, "init_level");
        rd(A_RISE, 32'h0, "init_rise");
        rd(A_FALL, 32'h0, "init_fall");
        rd(A_MASK, 32'h0, "init_mask");
        tick(1);
        check("rd_valid_pulse", {31'b0, rd_valid}, 32'd0);
        check("rd_idle_data", data_read, 32'd0);
        check("init_irq", {31'b0, irq}, 32'd0);

        // Pin 3 held high: LEVEL changes exactly at edge 18.
        gpio_i = 32'h8;
        tick(18);
        rd(A_LEVEL, 32'h0, "level_edge18_old");
        rd(A_LEVEL, 32'h8, "level_edge19");
        rd(A_RISE, 32'h8, "rise_b3");
        rd(A_RISE, 32'h0, "rise_b3_cleared");
        rd(A_FALL, 32'h0, "fall_b3_none");

        // 15-cycle glitch on pin 5 is rejected.
        gpio_i = 32'h28;
        tick(15);
        gpio_i = 32'h8;
        tick(30);
        rd(A_LEVEL, 32'h8, "glitch15_level");
        rd(A_RISE, 32'h0, "glitch15_rise");
        rd(A_FALL, 32'h0, "glitch15_fall");

        // 16-cycle pulse on pin 5 is accepted both ways.
        gpio_i = 32'h28;
        tick(16);
        gpio_i = 32'h8;
        tick(40);
        rd(A_RISE, 32'h20, "pulse16_rise");
        rd(A_FALL, 32'h20, "pulse16_fall");
        rd(A_LEVEL, 32'h8, "pulse16_level");

        // Masked rise on pin 0 drives irq one cycle after RISE sets.
        wr(A_MASK, 32'h1);
        tick(2);
        check("irq_mask_only", {31'b0, irq}, 32'd0);
        gpio_i = 32'h9;
        tick(18);
        check("irq_edge17", {31'b0, irq}, 32'd0);
        tick(1);
        check("irq_edge18", {31'b0, irq}, 32'd0);
        tick(1);
        check("irq_edge19", {31'b0, irq}, 32'd1);
        rd(A_RISE, 32'h1, "irq_rise_read");
        check("irq_after_read", {31'b0, irq}, 32'd1);
        tick(1);
        check("irq_cleared", {31'b0, irq}, 32'd0);

        // MASK cleared on the same edge FALL[0] sets: irq never asserts.
        gpio_i = 32'h8;
        tick(18);
        wr(A_MASK, 32'h0);
        check("irq_masked_e18", {31'b0, irq}, 32'd0);
        tick(1);
        check("irq_masked_e19", {31'b0, irq}, 32'd0);
        tick(1);
        check("irq_masked_e20", {31'b0, irq}, 32'd0);
        rd(A_FALL, 32'h1, "fall_b0");

        // Simultaneous read and write of MASK returns the old value.
        data_rd_en = 1'b1;
        data_wr_en = 1'b1;
        data_addr  = A_MASK;
        data_write = 32'h55;
        tick(1);
        data_rd_en = 1'b0;
        data_wr_en = 1'b0;
        check("rdwr_mask_vld", {31'b0, rd_valid}, 32'd1);
        check("rdwr_mask_old", data_read, 32'h0);
        rd(A_MASK, 32'h55, "mask_new");
        wr(A_LEVEL, 32'hFF);
        wr(A_RISE, 32'hFF);
        rd(A_MASK, 32'h55, "mask_ro_write_ignored");
        rd(A_RISE, 32'h0, "rise_write_ignored");

        // Read-clear racing a new event: bit 2 accepted on the capture edge.
        gpio_i = 32'hA;
        tick(5);
        gpio_i = 32'hE;
        tick(18);
        rd(A_RISE, 32'h2, "race_rise_old");
        rd(A_RISE, 32'h4, "race_rise_new");

        // Unmapped access just above the window.
        data_rd_en = 1'b1;
        data_addr  = BASE + 32'd16;
        tick(1);
        data_rd_en = 1'b0;
        check("unmapped_vld", {31'b0, rd_valid}, 32'd0);
        check("unmapped_data", data_read, 32'd0);

        // All pins high through reset: RISE appears at edge 18 after release.
        gpio_i = 32'hFFFF_FFFF;
        rst    = 1'b1;
        tick(3);
        rst = 1'b0;
        check("rst2_irq", {31'b0, irq}, 32'd0);
        tick(18);
        rd(A_RISE, 32'h0, "allhigh_rise_e18_old");
        rd(A_RISE, 32'hFFFF_FFFF, "allhigh_rise");
        rd(A_LEVEL, 32'hFFFF_FFFF, "allhigh_level");
        rd(A_MASK, 32'h0, "allhigh_mask");
        check("allhigh_irq", {31'b0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
